// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the ALU/load path and a
// buffered multi-cycle MDU result; writes are registered one cycle after grant.
module wb_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        regwrite,
    output logic [4:0]  wr_rd,
    output logic [31:0] wr_data
);

    typedef enum logic [1:0] {EMPTY, WAIT, FORCE} state_t;

    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    state_t      state;
    logic        buf_valid;
    logic [4:0]  buf_rd;
    logic [31:0] buf_data;
    logic [2:0]  wait_cnt;
    logic [2:0]  next_cnt;

    logic        grant;
    logic [4:0]  g_rd;
    logic [31:0] g_data;
    logic        mdu_take;

    assign mdu_ready = !buf_valid;
    assign mdu_take  = mdu_valid && mdu_ready;
    assign next_cnt  = wait_cnt + 3'd1;

    always_comb begin
        grant  = 1'b0;
        g_rd   = alu_rd;
        g_data = alu_data;
        case (state)
            EMPTY: grant = alu_valid;
            WAIT: begin
                grant = 1'b1;
                if (!alu_valid) begin
                    g_rd   = buf_rd;
                    g_data = buf_data;
                end
            end
            FORCE: begin
                // ALU request is ignored here; upstream re-presents it after the stall.
                grant  = 1'b1;
                g_rd   = buf_rd;
                g_data = buf_data;
            end
            default: grant = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            buf_valid <= 1'b0;
            buf_rd    <= 5'd0;
            buf_data  <= 32'd0;
            wait_cnt  <= 3'd0;
            alu_stall <= 1'b0;
            regwrite  <= 1'b0;
            wr_rd     <= 5'd0;
            wr_data   <= 32'd0;
        end else begin
            // x0 writes are consumed silently; the visible write port keeps its old value.
            regwrite <= grant && (g_rd != 5'd0);
            if (grant && (g_rd != 5'd0)) begin
                wr_rd   <= g_rd;
                wr_data <= g_data;
            end

            case (state)
                EMPTY: begin
                    if (mdu_take) begin
                        buf_valid <= 1'b1;
                        buf_rd    <= mdu_rd;
                        buf_data  <= mdu_data;
                        wait_cnt  <= 3'd0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (!alu_valid) begin
                        buf_valid <= 1'b0;
                        state     <= EMPTY;
                    end else begin
                        wait_cnt <= next_cnt;
                        if (next_cnt == STARVE_LIM) begin
                            state     <= FORCE;
                            alu_stall <= 1'b1;
                        end
                    end
                end
                FORCE: begin
                    buf_valid <= 1'b0;
                    alu_stall <= 1'b0;
                    state     <= EMPTY;
                end
                default: begin
                    buf_valid <= 1'b0;
                    alu_stall <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random writeback traffic checked against a queue-based model of
// the arbitration rules (one buffered MDU result, starvation bound, x0 suppression).
module tb_wb_port_arbiter;

    localparam int STARVE = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        regwrite;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;

    // Reference model: pending MDU results, how many ALU wins they have suffered,
    // whether the next cycle is a forced MDU slot, and the expected write port.
    logic [4:0]  q_rd[$];
    logic [31:0] q_dat[$];
    int          losses;
    logic        forcing;
    logic        m_rw;
    logic [4:0]  m_wr_rd;
    logic [31:0] m_wr_data;

    wb_port_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .mdu_valid (mdu_valid),
        .mdu_rd    (mdu_rd),
        .mdu_data  (mdu_data),
        .mdu_ready (mdu_ready),
        .regwrite  (regwrite),
        .wr_rd     (wr_rd),
        .wr_data   (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_rd.delete();
        q_dat.delete();
        losses    = 0;
        forcing   = 1'b0;
        m_rw      = 1'b0;
        m_wr_rd   = 5'd0;
        m_wr_data = 32'd0;
    endtask

    task automatic check_outputs();
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, (q_rd.size() == 0)});
        chk("alu_stall", {31'd0, alu_stall}, {31'd0, forcing});
        chk("regwrite",  {31'd0, regwrite},  {31'd0, m_rw});
        chk("wr_rd",     {27'd0, wr_rd},     {27'd0, m_wr_rd});
        chk("wr_data",   wr_data,            m_wr_data);
    endtask

    // Called at a falling edge: check, drive, advance the model, run one clock.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        logic        g;
        logic [4:0]  g_rd;
        logic [31:0] g_dat;
        logic        was_empty;
        check_outputs();
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;

        was_empty = (q_rd.size() == 0);
        g = 1'b0; g_rd = 5'd0; g_dat = 32'd0;
        if (forcing) begin
            g = 1'b1; g_rd = q_rd.pop_front(); g_dat = q_dat.pop_front();
            forcing = 1'b0;
        end else if (!was_empty && !av) begin
            g = 1'b1; g_rd = q_rd.pop_front(); g_dat = q_dat.pop_front();
        end else if (av) begin
            g = 1'b1; g_rd = ard; g_dat = ad;
            if (!was_empty) begin
                losses++;
                if (losses == STARVE) forcing = 1'b1;
            end
        end
        if (was_empty && mv) begin
            q_rd.push_back(mrd);
            q_dat.push_back(md);
            losses = 0;
        end
        m_rw = g && (g_rd != 5'd0);
        if (m_rw) begin
            m_wr_rd   = g_rd;
            m_wr_data = g_dat;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
        model_reset();
        #1;
        chk("rst_regwrite", {31'd0, regwrite},  32'd0);
        chk("rst_wr_rd",    {27'd0, wr_rd},     32'd0);
        chk("rst_wr_data",  wr_data,            32'd0);
        chk("rst_stall",    {31'd0, alu_stall}, 32'd0);
        chk("rst_ready",    {31'd0, mdu_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU only
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        chk("alu_wr_rd", {27'd0, wr_rd}, 32'd5);
        chk("alu_wr_data", wr_data, 32'h1234);
        idle(1);

        // MDU on idle port
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA);
        idle(3);

        // Starvation with ALU held busy
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hBEEF);
        for (int i = 0; i < 6; i++) step(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'd0, 32'd0);
        idle(2);

        // Back-pressure on a second MDU result
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h1111);
        step(1'b1, 5'd4, 32'h4444, 1'b1, 5'd6, 32'h2222);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h2222);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h2222);
        idle(3);

        // x0 destinations from both sources
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5);
        idle(3);

        // Reset while a result is buffered
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hCAFE);
        rst_n = 1'b0;
        #1;
        chk("midrst_regwrite", {31'd0, regwrite},  32'd0);
        chk("midrst_ready",    {31'd0, mdu_ready}, 32'd1);
        chk("midrst_stall",    {31'd0, alu_stall}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)), $urandom(),
                 ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom());
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
